// File: rtl/floo_vc_receiver.sv
// Receive side of a virtual-channel link: one shared flit bus is steered into
// per-VC FIFOs, and each VC returns its own not-full ready upstream.
module floo_vc_receiver #(
    parameter int unsigned NumVirtChannels = 2,
    parameter int unsigned Depth           = 2,
    parameter type         flit_t          = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumVirtChannels-1:0] valid_i,
    output logic [NumVirtChannels-1:0] ready_o,
    input  flit_t                      data_i,
    output logic [NumVirtChannels-1:0] valid_o,
    input  logic [NumVirtChannels-1:0] ready_i,
    output flit_t                      data_o [NumVirtChannels],
    output logic                       err_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(Depth);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);

    if (NumVirtChannels < 2) begin : g_bad_num_vc
        $fatal(1, "floo_vc_receiver: NumVirtChannels must be >= 2");
    end
    if (Depth < 2) begin : g_bad_depth
        $fatal(1, "floo_vc_receiver: Depth must be >= 2");
    end

    // Pointers wrap explicitly so Depth need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] nxt;
        if (ptr == PtrLast) begin
            nxt = {PtrW{1'b0}};
        end else begin
            nxt = ptr + PtrW'(1);
        end
        return nxt;
    endfunction

    function automatic logic multi_hot(input logic [NumVirtChannels-1:0] vec);
        return (vec & (vec - NumVirtChannels'(1))) != {NumVirtChannels{1'b0}};
    endfunction

    logic [PtrW-1:0] rd_ptr_q [NumVirtChannels];
    logic [PtrW-1:0] rd_ptr_d [NumVirtChannels];
    logic [PtrW-1:0] wr_ptr_q [NumVirtChannels];
    logic [PtrW-1:0] wr_ptr_d [NumVirtChannels];
    logic [CntW-1:0] cnt_q    [NumVirtChannels];
    logic [CntW-1:0] cnt_d    [NumVirtChannels];
    flit_t           mem_q    [NumVirtChannels][Depth];
    flit_t           mem_d    [NumVirtChannels][Depth];
    logic            err_q;
    logic            err_d;

    logic [NumVirtChannels-1:0] push_s;
    logic [NumVirtChannels-1:0] pop_s;

    // Multi-hot valid_i pushes every ready VC, matching what upstream saw.
    assign push_s = valid_i & ready_o;
    assign pop_s  = valid_o & ready_i;
    assign err_o  = err_q;

    // Outputs come straight from registered state, never from valid_i/ready_i.
    always_comb begin
        ready_o = {NumVirtChannels{1'b0}};
        valid_o = {NumVirtChannels{1'b0}};
        for (int v = 0; v < NumVirtChannels; v++) begin
            ready_o[v] = (cnt_q[v] != CntFull);
            valid_o[v] = (cnt_q[v] != {CntW{1'b0}});
            data_o[v]  = mem_q[v][rd_ptr_q[v]];
        end
    end

    // Next-state for pointers, occupancy, storage and the sticky error.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        for (int v = 0; v < NumVirtChannels; v++) begin
            if (push_s[v]) begin
                mem_d[v][wr_ptr_q[v]] = data_i;
                wr_ptr_d[v]           = ptr_inc(wr_ptr_q[v]);
            end else begin
                wr_ptr_d[v] = wr_ptr_q[v];
            end
            if (pop_s[v]) begin
                rd_ptr_d[v] = ptr_inc(rd_ptr_q[v]);
            end else begin
                rd_ptr_d[v] = rd_ptr_q[v];
            end
            case ({push_s[v], pop_s[v]})
                2'b10:   cnt_d[v] = cnt_q[v] + CntW'(1);
                2'b01:   cnt_d[v] = cnt_q[v] - CntW'(1);
                default: cnt_d[v] = cnt_q[v];
            endcase
        end
        err_d = err_q | multi_hot(valid_i);
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int v = 0; v < NumVirtChannels; v++) begin
                rd_ptr_q[v] <= {PtrW{1'b0}};
                wr_ptr_q[v] <= {PtrW{1'b0}};
                cnt_q[v]    <= {CntW{1'b0}};
            end
            err_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Flit storage needs no reset: entries are only read while count is nonzero.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule
